// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   PC_STEP          byte distance between sequential instructions
//   INSTR_W / PC_W   instruction and PC widths
//   DEFAULT_RESET_PC default first fetch address after reset
//   fetch_pkt_t      {pc, instr} pair carried through the output buffer
package fetch_pkg;

  localparam int              INSTR_W          = 32;
  localparam int              PC_W             = 32;
  localparam logic [PC_W-1:0] PC_STEP          = 32'd4;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch packets; output buffer of the fetch stage.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (empties the FIFO)
//   push_i         write data_i at the tail
//   pop_i          drop the head entry (ignored when empty)
//   flush_i        discard all entries; dominates push and pop
//   data_i         packet to write
//   head_o         packet at the head (undefined when empty)
//   count_o        number of live entries
//   empty_o/full_o occupancy flags
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  fetch_pkt_t    data_i,
  output fetch_pkt_t    head_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_pkt_t    mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // A simultaneous pop frees the slot, so a push into a full FIFO is legal then.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from a 1-cycle-latency
// instruction memory and hands {instr, pc} pairs downstream over valid/ready.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   imem_req_o      fetch request this cycle
//   imem_addr_o     fetch address (current PC)
//   imem_rdata_i    instruction word, one cycle after the request
//   redirect_i      taken branch/jump: flush and restart at redirect_pc_i
//   redirect_pc_i   redirect target (low two bits ignored)
//   instr_o, pc_o   head instruction and its PC (zero when not valid)
//   valid_o         head holds a live fetch
//   ready_i         downstream accepts this cycle
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               valid_o,
  input  logic               ready_i
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;

  fetch_pkt_t      fifo_head, fifo_data;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty, fifo_full;
  logic            pop, push;
  logic [CW:0]     occupancy;

  assign valid_o = ~fifo_empty;
  assign pop     = valid_o & ready_i;
  // A response is pushed unless a redirect squashes it this cycle.
  assign push    = inflight_q & ~redirect_i;

  // Slots already committed after this cycle's pop; pop implies count >= 1,
  // so the subtraction cannot wrap.
  assign occupancy  = {1'b0, fifo_count} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
  assign imem_req_o = ~rst_i & ~redirect_i & (occupancy < (CW + 1)'(FIFO_DEPTH));
  assign imem_addr_o = pc_q;

  assign fifo_data = '{pc: inflight_pc_q, instr: imem_rdata_i};

  assign instr_o = valid_o ? fifo_head.instr : '0;
  assign pc_o    = valid_o ? fifo_head.pc    : '0;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_i) begin
      pc_d = redirect_pc_i & ~32'd3;
    end else if (imem_req_o) begin
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
      pc_d          = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .data_i  (fifo_data),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // The credit check on requests means a response never meets a full buffer.
  a_no_push_full : assert property (@(posedge clk_i) disable iff (rst_i) push |-> !fifo_full);

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        valid;
  logic        ready = 1'b1;

  int checks = 0;
  int errors = 0;

  // Reference model: expected PC stream held as a queue of fetched PCs.
  logic [31:0] mq[$];
  logic [31:0] m_pc = 32'h0;
  bit          m_inf = 1'b0;
  logic [31:0] m_inf_pc = 32'h0;
  logic [31:0] nxt_rdata = 32'h0;
  logic [31:0] dlv[$];

  if_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (imem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_o       (instr),
    .pc_o          (pc),
    .valid_o       (valid),
    .ready_i       (ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare against the
  // model mid-cycle, then advance the model to the state after the rising edge.
  task automatic cyc(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
    bit          e_valid, e_pop, e_req;
    logic [31:0] e_pc, e_instr;
    @(negedge clk);
    rst         = r;
    redirect    = rd;
    redirect_pc = rpc;
    ready       = rdy;
    imem_rdata  = nxt_rdata;
    #1;
    e_valid = (mq.size() > 0);
    e_pc    = e_valid ? mq[0] : 32'h0;
    e_instr = e_valid ? mem_word(mq[0]) : 32'h0;
    e_pop   = e_valid && rdy;
    e_req   = !r && !rd && ((mq.size() + int'(m_inf) - int'(e_pop)) < DEPTH);
    chk("valid_o", 32'(valid), 32'(e_valid));
    chk("pc_o", pc, e_pc);
    chk("instr_o", instr, e_instr);
    chk("imem_req_o", 32'(imem_req), 32'(e_req));
    if (e_req && imem_req) chk("imem_addr_o", imem_addr, m_pc);
    if (valid && rdy) dlv.push_back(pc);
    nxt_rdata = imem_req ? mem_word(imem_addr) : $urandom();
    if (r) begin
      mq.delete();
      m_pc     = 32'h0;
      m_inf    = 1'b0;
      m_inf_pc = 32'h0;
    end else if (rd) begin
      mq.delete();
      m_pc  = rpc & ~32'd3;
      m_inf = 1'b0;
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (m_inf) mq.push_back(m_inf_pc);
      if (e_req) begin
        m_inf_pc = m_pc;
        m_pc     = m_pc + 32'd4;
        m_inf    = 1'b1;
      end else begin
        m_inf = 1'b0;
      end
    end
  endtask

  initial begin
    nxt_rdata = $urandom();

    // Reset, then streaming with ready held high.
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    dlv.delete();
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1);
    chk("t1_deliveries", 32'(dlv.size()), 32'd18);
    chk("t1_first_pc", dlv[0], 32'h0);
    chk("t1_second_pc", dlv[1], 32'h4);
    chk("t1_third_pc", dlv[2], 32'h8);

    // Stall from cycle 4 for 5 cycles; sequence must resume without gaps.
    cyc(1, 0, 0, 1);
    dlv.delete();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1);
    chk("t2_deliveries", 32'(dlv.size()), 32'd11);
    for (int i = 0; i < dlv.size(); i++) chk("t2_seq", dlv[i], 32'(4 * i));

    // Redirect while the buffer is full.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    dlv.delete();
    cyc(0, 1, 32'h100, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);
    chk("t3_target", dlv[0], 32'h100);
    chk("t3_next", dlv[1], 32'h104);

    // Redirect to the top of the address space: PC wraps to zero.
    cyc(0, 1, 32'hFFFF_FFFC, 1);
    dlv.delete();
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);
    chk("t4_top", dlv[0], 32'hFFFF_FFFC);
    chk("t4_wrap", dlv[1], 32'h0);

    // Reset pulse with a full buffer.
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    dlv.delete();
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);
    chk("t5_restart", dlv[0], 32'h0);

    // Back-to-back redirects: the later target wins.
    cyc(0, 1, 32'h200, 1);
    cyc(0, 1, 32'h300, 1);
    dlv.delete();
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);
    chk("t6_target", dlv[0], 32'h300);
    chk("t6_next", dlv[1], 32'h304);

    // Random traffic: backpressure, redirects to arbitrary (unaligned) targets, resets.
    for (int i = 0; i < 800; i++) begin
      logic        r, rd, rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 99) < 1);
      rd  = ($urandom_range(0, 99) < 6);
      rdy = ($urandom_range(0, 99) < 70);
      rpc = $urandom();
      cyc(r, rd, rpc, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
